hazard_ctrl_mc: RTL
===================

Name: hazard_ctrl_mc

Overview:
- Parametrised, multi-cycle successor to the combinational pipeline hazard unit of the 5-stage core.
- Sits beside IF/ID/EX. Detects load-use (RAW) and structural memory conflicts and drives `pc_keep`, `if_keep`, `if_clear` and `id_clear`.
- Adds configurable stall lengths via a small FSM, per-operand read enables, branch-error flush with stall abort, and a saturating stall-cycle counter.

Parameters:
- REG_W, 4, register index width.
- NULL_REG, 4'b1111 (REG_W bits), index meaning "no write"; never matches.
- LOAD_LAT, 1, total stall cycles for a load-use hazard (≥1).
- MEM_LAT, 1, total stall cycles for a memory conflict (≥1).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- error  in  1  branch/jump misprediction from EX; flush request.
- read_reg1  in  REG_W  ID source operand 1 index.
- read_reg2  in  REG_W  ID source operand 2 index.
- read_en1  in  1  operand 1 actually read.
- read_en2  in  1  operand 2 actually read.
- ex_write_reg  in  REG_W  EX destination index.
- ex_is_load  in  1  EX instruction is a memory read.
- mem_conflict  in  1  level; data access needs the instruction memory this cycle.
- cnt_clr  in  1  synchronous clear of stall_count.
- pc_keep  out  1  hold PC.
- if_keep  out  1  hold IF/ID register.
- if_clear  out  1  bubble IF/ID register.
- id_clear  out  1  bubble ID/EX register.
- stall_state  out  2  FSM state encoding: 0 RUN, 1 LOAD_STALL, 2 MEM_STALL.
- stall_count  out  CNT_W  saturating count of cycles with pc_keep=1.

Behaviour:
- LU is defined as: `ex_is_load && ex_write_reg != NULL_REG && ((read_en1 && read_reg1 == ex_write_reg) || (read_en2 && read_reg2 == ex_write_reg))`.
- Reset (async, any state, including mid-stall):
  - state=RUN, cnt=0, stall_count=0.
  - pc_keep, if_keep, if_clear and id_clear all read 0 while rst=1.
- Outputs are combinational from the registered state plus current inputs. Zero-latency detection in RUN.
- RUN, first matching rule applies:
  - LU: pc_keep=1, if_keep=1, id_clear=1, if_clear=0. mem_conflict is ignored this cycle; its source holds the level. If LOAD_LAT>1: next state LOAD_STALL, cnt<=LOAD_LAT-1.
  - mem_conflict: pc_keep=1, if_clear=1. If MEM_LAT>1: next state MEM_STALL, cnt<=MEM_LAT-1.
  - error (alone, or combined with mem_conflict): if_clear=1.
  - error with LU: LU rule applies and if_clear is additionally asserted. if_keep wins over if_clear at the IF/ID register.
  - No event: all outputs 0.
- LOAD_STALL:
  - Outputs: pc_keep=1, if_keep=1, id_clear=1. LU and mem_conflict are ignored.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
  - Total stall including the detect cycle is exactly LOAD_LAT cycles.
  - error in this state aborts the stall: outputs are if_clear=1, id_clear=1, pc_keep=0, if_keep=0; next state RUN; cnt<=0.
- MEM_STALL:
  - Outputs: pc_keep=1, if_clear=1. mem_conflict and LU are ignored.
  - cnt decrements each cycle. When cnt==1, next state is RUN. Total stall is MEM_LAT cycles.
  - error: no additional effect (if_clear already 1); the stall completes normally.
- On return to RUN, hazards are re-evaluated in the same cycle; back-to-back stalls are legal with no gap.
- stall_count:
  - Increments by 1 on each clk edge where pc_keep=1. Saturates at all-ones; no wrap.
  - cnt_clr forces 0 and has priority over increment.
- cnt width: clog2 of max(LOAD_LAT, MEM_LAT)+1. Unused when both latencies are 1, in which case the FSM never leaves RUN.
- With LOAD_LAT=MEM_LAT=1, the outputs are identical cycle-for-cycle to the prior single-cycle unit, except that read_en gating suppresses false RAW stalls.

Test Plan:
- LOAD_LAT=1, MEM_LAT=1. Drive ex_is_load=1, ex_write_reg=3, read_reg1=3, read_en1=1 for one cycle → pc_keep=if_keep=id_clear=1 and if_clear=0 that cycle only; stall_state stays 0; stall_count=1.
- LOAD_LAT=3. Same hazard for one cycle, then ex_is_load=0 → pc_keep high for exactly 3 cycles; stall_state sequence 0,1,1,0; stall_count=3.
- Drive ex_write_reg=NULL_REG=15 with read_reg2=15, read_en2=1; then read_reg1=3 matching with read_en1=0 → no stall in either case; all outputs 0.
- MEM_LAT=2. Assert mem_conflict together with LU in RUN → LU outputs only (if_clear=0). Next cycle (LOAD_LAT=1) with mem_conflict still high → pc_keep=if_clear=1 for 2 cycles.
- LOAD_LAT=4. Enter LOAD_STALL, assert error on the second stall cycle → that cycle if_clear=id_clear=1 and pc_keep=if_keep=0; stall_state=0 next cycle.
- Force stall_count to all-ones via CNT_W=2 and 5 stall cycles → count holds at 3. Pulse cnt_clr → 0. Assert rst mid-MEM_STALL → outputs drop to 0 immediately and stall_state=0.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// rtl/hazard_ctrl_mc_if.sv - pipeline-side signal bundle for the multi-cycle hazard unit
interface hazard_ctrl_mc_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             error;
  logic [REG_W-1:0] read_reg1;
  logic [REG_W-1:0] read_reg2;
  logic             read_en1;
  logic             read_en2;
  logic [REG_W-1:0] ex_write_reg;
  logic             ex_is_load;
  logic             mem_conflict;
  logic             cnt_clr;
  logic             pc_keep;
  logic             if_keep;
  logic             if_clear;
  logic             id_clear;
  logic [1:0]       stall_state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output error, read_reg1, read_reg2, read_en1, read_en2,
           ex_write_reg, ex_is_load, mem_conflict, cnt_clr,
    input  pc_keep, if_keep, if_clear, id_clear, stall_state, stall_count
  );

  modport slave (
    input  error, read_reg1, read_reg2, read_en1, read_en2,
           ex_write_reg, ex_is_load, mem_conflict, cnt_clr,
    output pc_keep, if_keep, if_clear, id_clear, stall_state, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - load-use / memory-conflict hazard unit with configurable stall lengths
module hazard_ctrl_mc #(
  parameter int               REG_W    = 4,
  parameter logic [REG_W-1:0] NULL_REG = {REG_W{1'b1}},
  parameter int               LOAD_LAT = 1,
  parameter int               MEM_LAT  = 1,
  parameter int               CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_mc_if.slave bus
);
  localparam int MAX_LAT = (LOAD_LAT > MEM_LAT) ? LOAD_LAT : MEM_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LOAD_RELOAD = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] MEM_RELOAD  = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_STALL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             lu;
  logic             pc_keep, if_keep, if_clear, id_clear;

  assign lu = bus.ex_is_load && (bus.ex_write_reg != NULL_REG) &&
              ((bus.read_en1 && (bus.read_reg1 == bus.ex_write_reg)) ||
               (bus.read_en2 && (bus.read_reg2 == bus.ex_write_reg)));

  always_comb begin
    pc_keep  = 1'b0;
    if_keep  = 1'b0;
    if_clear = 1'b0;
    id_clear = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      RUN: begin
        if (lu) begin
          pc_keep  = 1'b1;
          if_keep  = 1'b1;
          id_clear = 1'b1;
          if_clear = bus.error;
          if (LOAD_LAT > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = LOAD_RELOAD;
          end
        end else if (bus.mem_conflict) begin
          pc_keep  = 1'b1;
          if_clear = 1'b1;
          if (MEM_LAT > 1) begin
            state_d = MEM_STALL;
            cnt_d   = MEM_RELOAD;
          end
        end else if (bus.error) begin
          if_clear = 1'b1;
        end
      end
      LOAD_STALL: begin
        // A misprediction makes the stalled instructions dead, so drop the stall and flush.
        if (bus.error) begin
          if_clear = 1'b1;
          id_clear = 1'b1;
          state_d  = RUN;
          cnt_d    = '0;
        end else begin
          pc_keep  = 1'b1;
          if_keep  = 1'b1;
          id_clear = 1'b1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      MEM_STALL: begin
        pc_keep  = 1'b1;
        if_clear = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.cnt_clr) stall_count_d = '0;
    else if (pc_keep && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Controls are forced low while reset is held so the pipeline never sees a stale stall.
  assign bus.pc_keep     = pc_keep  & ~rst;
  assign bus.if_keep     = if_keep  & ~rst;
  assign bus.if_clear    = if_clear & ~rst;
  assign bus.id_clear    = id_clear & ~rst;
  assign bus.stall_state = state_q;
  assign bus.stall_count = stall_count_q;
endmodule
